fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the fetch stage and the IF/ID pipeline register.
- Owns the PC and issues instruction-memory reads.
- Tracks multi-cycle fetches, discards in-flight data after a redirect, and buffers late-returning instructions while the front end is held.
- Drives done_fetch, flush, stall and halt into IF/ID; sits between the instruction memory, the hazard unit and IF/ID.

Parameters:
- ADDR_W, 16, PC and fetch address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating fetch-stall cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_done  in  1  instruction memory returns data this cycle.
- imem_stall  in  1  instruction memory busy; request not yet complete.
- imem_data  in  16  instruction word, valid when imem_done=1.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  ADDR_W  redirect PC.
- load_use_hazard  in  1  hazard unit requests a decode stall.
- stall_mem_stg  in  1  memory stage stalled; the whole front end freezes.
- halt_decoded  in  1  HALT instruction present in decode.
- imem_rd_en  out  1  read request.
- imem_addr  out  ADDR_W  read address; always equals pc_q.
- pc_q  out  ADDR_W  current fetch PC.
- instr_out  out  16  instruction to IF/ID.
- done_fetch  out  1  instr_out is valid; IF/ID captures it.
- flush_ifid  out  1  IF/ID loads NOP (16'h0800).
- stall_ifid  out  1  IF/ID holds its contents.
- stall_fetch  out  1  fetch not advancing this cycle.
- halt_fetch  out  1  sticky halt indication.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_fetch=1.

Behaviour:
- Derived signals: hold = stall_mem_stg | load_use_hazard. redirect = branch_taken & ~stall_mem_stg.
- redirect has priority over load_use_hazard and halt_decoded.
- Reset (rst=0, asynchronous):
  - state=RUN, pc_q=RESET_PC, buffer=16'h0800, stall_cnt=0.
  - All 1-bit outputs are 0; instr_out=16'h0800.
- All outputs are combinational from state plus inputs, except pc_q and stall_cnt, which are registered.
- RUN:
  - imem_rd_en = ~hold & ~redirect; instr_out = imem_data.
  - imem_done & rd_en: done_fetch=1, pc_q<=pc_q+2 (wraps modulo 2^ADDR_W).
  - rd_en & imem_stall & ~imem_done: go to WAIT.
- WAIT:
  - imem_rd_en=1; address held.
  - imem_done & ~hold & ~redirect: done_fetch=1, pc_q<=pc_q+2, go to RUN.
  - imem_done & hold & ~redirect: capture imem_data into buffer, pc_q<=pc_q+2, go to BUFD; done_fetch=0.
- BUFD:
  - imem_rd_en=0; instr_out=buffer.
  - ~hold: done_fetch=1, go to RUN.
  - redirect: discard the buffer, go to RUN.
- DROP:
  - imem_rd_en=0; done_fetch=0.
  - imem_done: discard the data, go to RUN.
- HALTED: imem_rd_en=0, done_fetch=0, halt_fetch=1, pc_q frozen. Exit only via reset.
- redirect in any non-HALTED state:
  - pc_q<=branch_target, flush_ifid=1, done_fetch=0.
  - From WAIT: go to DROP.
  - From DROP: stay in DROP.
  - From RUN or BUFD: go to RUN.
- halt_decoded & ~redirect & ~stall_mem_stg: go to HALTED next cycle.
  - Exception: when in WAIT, first complete or drop the outstanding read, then enter HALTED.
- stall_ifid = hold. stall_fetch = hold | (state ∈ {WAIT, DROP, BUFD}).
- stall_cnt increments when stall_fetch=1 and saturates at all-ones.
- A simultaneous imem_done and redirect in WAIT is a discard; DROP is not entered, go to RUN.

Decomposition:
- Shared package holds:
  - State enum: RUN=0, WAIT=1, DROP=2, BUFD=3, HALTED=4 (3 bits).
  - NOP_INSTR=16'h0800.
  - PC_INC=2.
- Natural sub-module: sat_counter (CNT_W), reused by other performance counters.

Test Plan:
- Reset release, imem_done tied 1: pc_q steps 0,2,4,6. done_fetch=1 every cycle. stall_cnt stays 0.
- imem_stall for 3 cycles at pc 0x0010, then done with data 0xA123: state goes WAIT ×3. instr_out=0xA123 with done_fetch=1. pc_q becomes 0x0012. stall_cnt=3.
- branch_taken to 0x0100 while in WAIT, then imem_done with 0xBEEF: flush_ifid pulses once. 0xBEEF is never presented. Next fetch address is 0x0100.
- Data 0x1234 returns in WAIT with stall_mem_stg=1 for 2 cycles: done_fetch stays 0 while held. When the stall drops, instr_out=0x1234 with done_fetch=1 exactly once.
- load_use_hazard and branch_taken in the same cycle: redirect wins. pc_q=target, flush_ifid=1.
- halt_decoded at pc 0x0020: halt_fetch=1 and imem_rd_en=0 from then on; pc_q frozen. rst pulse low mid-halt returns to RESET_PC, state RUN.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller and its helpers.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    WAIT   = 3'd1,
    DROP   = 3'd2,
    BUFD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int          PC_INC    = 2;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues imem reads, tracks multi-cycle
// fetches, discards reads orphaned by a redirect and buffers data that
// returns while the front end is held.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_done,
  input  logic              imem_stall,
  input  logic [15:0]       imem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              load_use_hazard,
  input  logic              stall_mem_stg,
  input  logic              halt_decoded,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_q,
  output logic [15:0]       instr_out,
  output logic              done_fetch,
  output logic              flush_ifid,
  output logic              stall_ifid,
  output logic              stall_fetch,
  output logic              halt_fetch,
  output logic [CNT_W-1:0]  stall_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [15:0]       buf_q, buf_d;
  logic              hold, redirect, halt_go;
  fetch_state_e      done_next;
  logic [ADDR_W-1:0] pc_inc;

  assign hold      = stall_mem_stg | load_use_hazard;
  assign redirect  = branch_taken & ~stall_mem_stg;
  assign halt_go   = halt_decoded & ~stall_mem_stg;
  assign done_next = halt_go ? HALTED : RUN;
  assign pc_inc    = pc_q + ADDR_W'(PC_INC);
  assign imem_addr = pc_q;

  // Next-state, PC, buffer and all combinational outputs; outputs are forced
  // to their idle values while reset is asserted.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    imem_rd_en  = 1'b0;
    instr_out   = imem_data;
    done_fetch  = 1'b0;
    flush_ifid  = 1'b0;
    stall_ifid  = hold;
    stall_fetch = hold | (state_q == WAIT) | (state_q == DROP) | (state_q == BUFD);
    halt_fetch  = 1'b0;

    unique case (state_q)
      RUN: begin
        imem_rd_en = ~hold & ~redirect & ~halt_go;
        if (redirect) begin
          pc_d       = branch_target;
          flush_ifid = 1'b1;
        end else if (halt_go) begin
          state_d = HALTED;
        end else if (imem_rd_en && imem_done) begin
          done_fetch = 1'b1;
          pc_d       = pc_inc;
        end else if (imem_rd_en && imem_stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        imem_rd_en = 1'b1;
        if (redirect) begin
          // A read completing together with the redirect is simply dropped.
          pc_d       = branch_target;
          flush_ifid = 1'b1;
          state_d    = imem_done ? RUN : DROP;
        end else if (imem_done && !hold) begin
          done_fetch = 1'b1;
          pc_d       = pc_inc;
          state_d    = done_next;
        end else if (imem_done) begin
          buf_d   = imem_data;
          pc_d    = pc_inc;
          state_d = BUFD;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_d       = branch_target;
          flush_ifid = 1'b1;
          // If the orphaned read lands now there is nothing left to drop.
          state_d    = imem_done ? RUN : DROP;
        end else if (imem_done) begin
          state_d = done_next;
        end
      end
      BUFD: begin
        instr_out = buf_q;
        if (redirect) begin
          pc_d       = branch_target;
          flush_ifid = 1'b1;
          buf_d      = NOP_INSTR;
          state_d    = RUN;
        end else if (!hold) begin
          done_fetch = 1'b1;
          state_d    = done_next;
        end
      end
      HALTED: begin
        instr_out  = NOP_INSTR;
        halt_fetch = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst) begin
      imem_rd_en  = 1'b0;
      instr_out   = NOP_INSTR;
      done_fetch  = 1'b0;
      flush_ifid  = 1'b0;
      stall_ifid  = 1'b0;
      stall_fetch = 1'b0;
      halt_fetch  = 1'b0;
    end
  end

  // State, PC and late-data buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_fetch),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl plus a narrow sat_counter for saturation.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_done = 1'b0, imem_stall = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        load_use_hazard = 1'b0, stall_mem_stg = 1'b0, halt_decoded = 1'b0;
  logic        imem_rd_en, done_fetch, flush_ifid, stall_ifid, stall_fetch, halt_fetch;
  logic [15:0] imem_addr, pc_q, instr_out, stall_cnt;
  logic        sc_inc = 1'b0;
  logic [2:0]  sc_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_done(imem_done), .imem_stall(imem_stall),
    .imem_data(imem_data), .branch_taken(branch_taken), .branch_target(branch_target),
    .load_use_hazard(load_use_hazard), .stall_mem_stg(stall_mem_stg),
    .halt_decoded(halt_decoded), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .pc_q(pc_q), .instr_out(instr_out), .done_fetch(done_fetch),
    .flush_ifid(flush_ifid), .stall_ifid(stall_ifid), .stall_fetch(stall_fetch),
    .halt_fetch(halt_fetch), .stall_cnt(stall_cnt)
  );

  sat_counter #(.CNT_W(3)) u_sc (.clk(clk), .rst(rst), .inc(sc_inc), .cnt(sc_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs are set there), then settle.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic done, input logic stl, input logic [15:0] data);
    imem_done  = done;
    imem_stall = stl;
    imem_data  = data;
  endtask

  initial begin
    // Reset state, even with imem_done high
    imem_done = 1'b1;
    nxt();
    chk("rst_pc", pc_q, 16'h0000);
    chk("rst_rd_en", imem_rd_en, 1'b0);
    chk("rst_instr", instr_out, 16'h0800);
    chk("rst_done", done_fetch, 1'b0);
    chk("rst_halt", halt_fetch, 1'b0);
    chk("rst_cnt", stall_cnt, 16'h0000);

    // Streaming fetch: pc 0,2,4,6 with done every cycle
    @(negedge clk); rst = 1'b1;
    set_in(1'b1, 1'b0, 16'h1111);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("run_pc", pc_q, 16'(2 * i));
      chk("run_done", done_fetch, 1'b1);
      chk("run_rd_en", imem_rd_en, 1'b1);
      nxt();
    end
    chk("run_cnt", stall_cnt, 16'h0000);
    for (int i = 0; i < 4; i++) nxt();
    chk("pc_at_10", pc_q, 16'h0010);

    // Three-cycle WAIT, then 0xA123 returns
    set_in(1'b0, 1'b1, 16'h0000);
    #1;
    chk("wait_req", imem_rd_en, 1'b1);
    nxt();
    chk("wait_sf1", stall_fetch, 1'b1);
    chk("wait_addr", imem_addr, 16'h0010);
    nxt();
    chk("wait_sf2", stall_fetch, 1'b1);
    chk("wait_nodone", done_fetch, 1'b0);
    nxt();
    set_in(1'b1, 1'b0, 16'hA123);
    #1;
    chk("wait_instr", instr_out, 16'hA123);
    chk("wait_done", done_fetch, 1'b1);
    nxt();
    chk("wait_pc", pc_q, 16'h0012);
    chk("wait_cnt", stall_cnt, 16'd3);

    // Redirect during WAIT; 0xBEEF returns later and must be dropped
    set_in(1'b0, 1'b1, 16'h0000);
    nxt();
    branch_taken = 1'b1; branch_target = 16'h0100;
    #1;
    chk("br_flush", flush_ifid, 1'b1);
    chk("br_nodone", done_fetch, 1'b0);
    nxt();
    branch_taken = 1'b0;
    set_in(1'b1, 1'b0, 16'hBEEF);
    #1;
    chk("drop_pc", pc_q, 16'h0100);
    chk("drop_nodone", done_fetch, 1'b0);
    chk("drop_noflush", flush_ifid, 1'b0);
    chk("drop_rd_en", imem_rd_en, 1'b0);
    nxt();
    set_in(1'b0, 1'b0, 16'h0000);
    #1;
    chk("post_drop_addr", imem_addr, 16'h0100);
    chk("post_drop_rd", imem_rd_en, 1'b1);
    chk("post_drop_done", done_fetch, 1'b0);
    chk("post_drop_cnt", stall_cnt, 16'd5);

    // Data 0x1234 arrives while memory stage is stalled for two cycles
    set_in(1'b0, 1'b1, 16'h0000);
    nxt();
    set_in(1'b1, 1'b0, 16'h1234);
    stall_mem_stg = 1'b1;
    #1;
    chk("bufd_hold_done", done_fetch, 1'b0);
    chk("bufd_stall_ifid", stall_ifid, 1'b1);
    nxt();
    set_in(1'b0, 1'b0, 16'hFFFF);
    #1;
    chk("bufd_held_done", done_fetch, 1'b0);
    chk("bufd_rd_en", imem_rd_en, 1'b0);
    chk("bufd_pc", pc_q, 16'h0102);
    nxt();
    stall_mem_stg = 1'b0;
    #1;
    chk("bufd_instr", instr_out, 16'h1234);
    chk("bufd_done", done_fetch, 1'b1);
    nxt();
    chk("bufd_once", done_fetch, 1'b0);
    chk("bufd_cnt", stall_cnt, 16'd8);

    // PC wrap: redirect to 0xFFFE then one fetch
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    nxt();
    branch_taken = 1'b0;
    set_in(1'b1, 1'b0, 16'h2222);
    #1;
    chk("wrap_pc_pre", pc_q, 16'hFFFE);
    nxt();
    chk("wrap_pc", pc_q, 16'h0000);

    // Redirect beats load-use hazard
    load_use_hazard = 1'b1;
    branch_taken = 1'b1; branch_target = 16'h0020;
    #1;
    chk("prio_flush", flush_ifid, 1'b1);
    chk("prio_done", done_fetch, 1'b0);
    nxt();
    load_use_hazard = 1'b0; branch_taken = 1'b0;
    set_in(1'b0, 1'b0, 16'h0000);
    #1;
    chk("prio_pc", pc_q, 16'h0020);
    chk("prio_cnt", stall_cnt, 16'd9);

    // Halt at 0x0020; pc frozen, no reads, branches ignored
    halt_decoded = 1'b1;
    nxt();
    halt_decoded = 1'b0;
    set_in(1'b1, 1'b0, 16'h3333);
    #1;
    chk("halt_flag", halt_fetch, 1'b1);
    chk("halt_rd_en", imem_rd_en, 1'b0);
    nxt();
    branch_taken = 1'b1; branch_target = 16'h0400;
    #1;
    chk("halt_pc", pc_q, 16'h0020);
    chk("halt_nodone", done_fetch, 1'b0);
    nxt();
    branch_taken = 1'b0;
    #1;
    chk("halt_pc2", pc_q, 16'h0020);
    chk("halt_flag2", halt_fetch, 1'b1);

    // Reset pulse mid-halt
    rst = 1'b0;
    #1;
    chk("rerst_pc", pc_q, 16'h0000);
    chk("rerst_halt", halt_fetch, 1'b0);
    chk("rerst_cnt", stall_cnt, 16'h0000);
    nxt();
    rst = 1'b1;
    #1;
    chk("rerun_rd", imem_rd_en, 1'b1);
    chk("rerun_done", done_fetch, 1'b1);
    nxt();
    chk("rerun_pc", pc_q, 16'h0002);

    // Narrow counter saturates at all-ones
    sc_inc = 1'b1;
    for (int i = 0; i < 10; i++) nxt();
    chk("sat_cnt", sc_cnt, 3'd7);
    sc_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
